vga_timing: RTL and testbench

Raster timing generator and pixel output stage for the 800×480 LCD on the `pixel_clk` domain (32 MHz). It sits directly downstream of the top-level clock/reset logic and upstream of the video pins in `hws_ifm`. It generates the sync and data-enable signals and pulls pixels from the upstream pixel FIFO with a read strobe. It flags and counts underflow.

---
 rtl/video_pkg.sv | 33 +++
 rtl/vga_timing_if.sv | 43 ++++
 rtl/mod_counter.sv | 35 +++
 rtl/vga_timing.sv | 120 ++++++++++++
 tb/tb_vga_timing.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
// Shared types and default raster timing for the 800x480 LCD pixel path.
//   rgb_t     : packed RGB888 pixel, {r, g, b}
//   HDISP..VBP: default timing (pixels / lines)
//   HTOTAL/VTOTAL: full line / frame length including blanking
//   in_range  : half-open interval test lo <= cnt < hi
// -----------------------------------------------------------------------------
package video_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int HDISP  = 800;
  localparam int VDISP  = 480;
  localparam int HFP    = 40;
  localparam int HPULSE = 48;
  localparam int HBP    = 40;
  localparam int VFP    = 13;
  localparam int VPULSE = 3;
  localparam int VBP    = 29;

  localparam int HTOTAL = HFP + HPULSE + HBP + HDISP;  // 928
  localparam int VTOTAL = VFP + VPULSE + VBP + VDISP;  // 525

  function automatic logic in_range(input int cnt, input int lo, input int hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// -----------------------------------------------------------------------------
// vga_timing_if
// Pixel request bus between the raster timing generator and the pixel FIFO.
//   pix_data    : pixel offered by the FIFO (RGB888)
//   pix_valid   : pix_data holds a real pixel
//   pix_rd      : read strobe from the timing generator
//   pix_x/pix_y : coordinate of the pixel being requested (0 outside active)
//   frame_start : first cycle of each frame, for upstream realignment
//
// Handshake: the FIFO presents pix_data/pix_valid combinationally. A transfer
// happens on every rising edge where pix_rd is high; pix_rd is not held off by
// pix_valid, so a low pix_valid on such an edge is a starved read (the pixel
// slot is lost and shown black). There is no other back-pressure.
//
// Modports: master = timing generator, slave = pixel source.
// -----------------------------------------------------------------------------
interface vga_timing_if #(
  parameter int HDISP = video_pkg::HDISP,
  parameter int VDISP = video_pkg::VDISP
);
  import video_pkg::*;

  localparam int XW = $clog2(HDISP);
  localparam int YW = $clog2(VDISP);

  rgb_t          pix_data;
  logic          pix_valid;
  logic          pix_rd;
  logic          frame_start;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;

  modport master (
    input  pix_data, pix_valid,
    output pix_rd, frame_start, pix_x, pix_y
  );

  modport slave (
    output pix_data, pix_valid,
    input  pix_rd, frame_start, pix_x, pix_y
  );

endinterface

// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
// Wrapping counter 0..MAX-1 with enable.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   en_i       : advance the count this cycle
//   cnt_o      : current count
//   tc_o       : count is at its terminal value MAX-1 (independent of en_i)
// -----------------------------------------------------------------------------
module mod_counter #(
  parameter int MAX = 2,
  parameter int W   = $clog2(MAX)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == W'(MAX - 1));
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = tc_o ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
// Raster timing generator and pixel output stage for the LCD (pixel_clk domain).
// Each axis runs front porch, sync, back porch, then active. Pixels are pulled
// from the upstream FIFO during active and registered onto the video pins.
//   pixel_clk, pixel_rst_n : clock, asynchronous active-low reset
//   pix (master)           : pixel request bus (see vga_timing_if)
//   vga_hs, vga_vs         : syncs, active-low, registered
//   vga_de                 : data enable, registered
//   vga_rgb                : displayed pixel, registered (black on starve/blank)
//   underflow_cnt          : saturating count of starved reads, reset-only clear
// The four video outputs all reflect the previous cycle's counter state, so
// they stay mutually aligned with one cycle of latency behind pix_rd/pix_x/y.
// -----------------------------------------------------------------------------
module vga_timing #(
  parameter int HDISP  = video_pkg::HDISP,
  parameter int VDISP  = video_pkg::VDISP,
  parameter int HFP    = video_pkg::HFP,
  parameter int HPULSE = video_pkg::HPULSE,
  parameter int HBP    = video_pkg::HBP,
  parameter int VFP    = video_pkg::VFP,
  parameter int VPULSE = video_pkg::VPULSE,
  parameter int VBP    = video_pkg::VBP
) (
  input  logic            pixel_clk,
  input  logic            pixel_rst_n,
  vga_timing_if.master    pix,
  output logic            vga_hs,
  output logic            vga_vs,
  output logic            vga_de,
  output video_pkg::rgb_t vga_rgb,
  output logic [15:0]     underflow_cnt
);
  import video_pkg::*;

  localparam int HTOT = HFP + HPULSE + HBP + HDISP;
  localparam int VTOT = VFP + VPULSE + VBP + VDISP;
  localparam int HACT = HFP + HPULSE + HBP;
  localparam int VACT = VFP + VPULSE + VBP;
  localparam int HW   = $clog2(HTOT);
  localparam int VW   = $clog2(VTOT);
  localparam int XW   = $clog2(HDISP);
  localparam int YW   = $clog2(VDISP);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          h_tc;
  // Frame wrap is already visible as hcnt==vcnt==0; the V terminal count
  // has no consumer here.
  logic          v_tc_unused;

  mod_counter #(.MAX(HTOT), .W(HW)) u_hcnt (
    .clk   (pixel_clk),
    .rst_n (pixel_rst_n),
    .en_i  (1'b1),
    .cnt_o (hcnt),
    .tc_o  (h_tc)
  );

  mod_counter #(.MAX(VTOT), .W(VW)) u_vcnt (
    .clk   (pixel_clk),
    .rst_n (pixel_rst_n),
    .en_i  (h_tc),
    .cnt_o (vcnt),
    .tc_o  (v_tc_unused)
  );

  logic h_active, v_active, active;

  assign h_active = in_range(int'(hcnt), HACT, HTOT);
  assign v_active = in_range(int'(vcnt), VACT, VTOT);
  assign active   = h_active && v_active;

  // Request side is combinational from the counters.
  assign pix.pix_rd      = active;
  assign pix.pix_x       = active ? XW'(int'(hcnt) - HACT) : '0;
  assign pix.pix_y       = active ? YW'(int'(vcnt) - VACT) : '0;
  assign pix.frame_start = (hcnt == '0) && (vcnt == '0);

  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        de_q, de_d;
  rgb_t        rgb_q, rgb_d;
  logic [15:0] uf_q, uf_d;

  always_comb begin
    hs_d  = !in_range(int'(hcnt), HFP, HFP + HPULSE);
    vs_d  = !in_range(int'(vcnt), VFP, VFP + VPULSE);
    de_d  = active;
    rgb_d = '0;
    uf_d  = uf_q;
    if (active) begin
      if (pix.pix_valid) rgb_d = pix.pix_data;
      else if (uf_q != 16'hFFFF) uf_d = uf_q + 16'd1;
    end
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      de_q  <= 1'b0;
      rgb_q <= '0;
      uf_q  <= '0;
    end else begin
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      de_q  <= de_d;
      rgb_q <= rgb_d;
      uf_q  <= uf_d;
    end
  end

  assign vga_hs        = hs_q;
  assign vga_vs        = vs_q;
  assign vga_de        = de_q;
  assign vga_rgb       = rgb_q;
  assign underflow_cnt = uf_q;

endmodule

// File: tb/tb_vga_timing.sv
// -----------------------------------------------------------------------------
// tb_vga_timing
// Directed bench for vga_timing. The main instance uses a shrunken raster
// (HT=25, VT=11, frame=275) so whole frames fit in a short run; a second
// instance with a nearly all-active raster is starved from reset to reach
// underflow saturation.
// -----------------------------------------------------------------------------
module tb_vga_timing;

  localparam int HDISP = 16, VDISP = 6;
  localparam int HFP = 4, HPULSE = 3, HBP = 2;
  localparam int VFP = 2, VPULSE = 1, VBP = 2;
  localparam int HT    = HFP + HPULSE + HBP + HDISP;   // 25
  localparam int VT    = VFP + VPULSE + VBP + VDISP;   // 11
  localparam int HACT  = HFP + HPULSE + HBP;           // 9
  localparam int VACT  = VFP + VPULSE + VBP;           // 5
  localparam int FRAME = HT * VT;                      // 275

  // Saturation instance: porches/pulses of 1, HT=256, VT=512, 253 active/line.
  localparam int S_HDISP = 253, S_VDISP = 509;

  logic        clk, rst_n, rst_s_n;
  logic        hs, vs, de;
  logic [23:0] rgb;
  logic [15:0] uf;
  logic        hs_s, vs_s, de_s;
  logic [23:0] rgb_s;
  logic [15:0] uf_s;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rel_cyc;

  vga_timing_if #(.HDISP(HDISP), .VDISP(VDISP)) pif ();
  vga_timing_if #(.HDISP(S_HDISP), .VDISP(S_VDISP)) sif ();

  vga_timing #(
    .HDISP(HDISP), .VDISP(VDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP)
  ) dut (
    .pixel_clk(clk), .pixel_rst_n(rst_n), .pix(pif),
    .vga_hs(hs), .vga_vs(vs), .vga_de(de), .vga_rgb(rgb), .underflow_cnt(uf)
  );

  vga_timing #(
    .HDISP(S_HDISP), .VDISP(S_VDISP), .HFP(1), .HPULSE(1), .HBP(1),
    .VFP(1), .VPULSE(1), .VBP(1)
  ) dut_s (
    .pixel_clk(clk), .pixel_rst_n(rst_s_n), .pix(sif),
    .vga_hs(hs_s), .vga_vs(vs_s), .vga_de(de_s), .vga_rgb(rgb_s), .underflow_cnt(uf_s)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_hs"},  32'(hs), 32'd1);
    check({tag, "_vs"},  32'(vs), 32'd1);
    check({tag, "_de"},  32'(de), 32'd0);
    check({tag, "_rgb"}, 32'(rgb), 32'd0);
    check({tag, "_uf"},  32'(uf), 32'd0);
    check({tag, "_fs"},  32'(pif.frame_start), 32'd1);
    check({tag, "_rd"},  32'(pif.pix_rd), 32'd0);
  endtask

  // ---------------- reference model state ----------------
  int          s;            // rising edges since reset release
  logic        exp_hs, exp_vs, exp_de;
  logic [23:0] exp_rgb;
  logic [15:0] exp_uf;
  int          starve_left;
  logic        prev_hs, prev_vs, prev_de, prev_fs, prev_rd;
  int          hs_fall_s, vs_fall_s, fs_s, first_hs_fall, first_rd_s, first_de_s;
  int          de_run, lines, zero_de;
  logic        vs_seen;

  task automatic reset_model();
    s = 0;
    exp_hs = 1'b1; exp_vs = 1'b1; exp_de = 1'b0; exp_rgb = '0; exp_uf = '0;
    starve_left = 0;
    prev_hs = 1'b1; prev_vs = 1'b1; prev_de = 1'b0; prev_fs = 1'b0; prev_rd = 1'b0;
    hs_fall_s = -1; vs_fall_s = -1; fs_s = -1;
    first_hs_fall = -1; first_rd_s = -1; first_de_s = -1;
    de_run = 0; lines = 0; zero_de = 0; vs_seen = 1'b0;
  endtask

  // Called at a falling edge: check state s, drive the FIFO, advance one cycle.
  task automatic step();
    int          h, v;
    logic        act;
    logic [23:0] d;
    h   = s % HT;
    v   = (s / HT) % VT;
    act = (h >= HACT) && (v >= VACT);

    check("pix_rd", 32'(pif.pix_rd), 32'(act));
    check("pix_x", 32'(pif.pix_x), act ? 32'(h - HACT) : 32'd0);
    check("pix_y", 32'(pif.pix_y), act ? 32'(v - VACT) : 32'd0);
    check("frame_start", 32'(pif.frame_start), 32'((h == 0) && (v == 0)));
    check("vga_hs", 32'(hs), 32'(exp_hs));
    check("vga_vs", 32'(vs), 32'(exp_vs));
    check("vga_de", 32'(de), 32'(exp_de));
    check("vga_rgb", 32'(rgb), 32'(exp_rgb));
    check("underflow_cnt", 32'(uf), 32'(exp_uf));

    // Interval measurements on the observed outputs.
    if (prev_hs && !hs) begin
      if (hs_fall_s >= 0) check("hs_period", 32'(s - hs_fall_s), 32'(HT));
      else first_hs_fall = s;
      hs_fall_s = s;
    end
    if (!prev_hs && hs && hs_fall_s >= 0) check("hs_width", 32'(s - hs_fall_s), 32'(HPULSE));
    if (prev_vs && !vs) begin
      if (vs_seen) check("lines_per_frame", 32'(lines), 32'(VDISP));
      vs_seen = 1'b1;
      lines = 0;
      vs_fall_s = s;
    end
    if (!prev_vs && vs && vs_fall_s >= 0) check("vs_width", 32'(s - vs_fall_s), 32'(VPULSE * HT));
    if (pif.frame_start && !prev_fs) begin
      if (fs_s >= 0) check("frame_period", 32'(s - fs_s), 32'(FRAME));
      fs_s = s;
    end
    if (pif.pix_rd && !prev_rd && first_rd_s < 0) first_rd_s = s;
    if (de && !prev_de && first_de_s < 0) first_de_s = s;
    if (de) de_run++;
    if (de && rgb == 24'h0) zero_de++;
    if (prev_de && !de) begin
      check("de_per_line", 32'(de_run), 32'(HDISP));
      de_run = 0;
      lines++;
    end
    prev_hs = hs; prev_vs = vs; prev_de = de; prev_fs = pif.frame_start; prev_rd = pif.pix_rd;

    // FIFO output for this cycle.
    d = {8'(h - HACT), 8'(v - VACT), 8'hA5};
    pif.pix_data = d;
    if (act && starve_left > 0) begin
      pif.pix_valid = 1'b0;
      starve_left--;
    end else begin
      pif.pix_valid = 1'b1;
    end

    // Registered outputs expected after the coming edge.
    exp_hs  = !((h >= HFP) && (h < HFP + HPULSE));
    exp_vs  = !((v >= VFP) && (v < VFP + VPULSE));
    exp_de  = act;
    exp_rgb = (act && pif.pix_valid) ? d : 24'h0;
    if (act && !pif.pix_valid && exp_uf != 16'hFFFF) exp_uf = exp_uf + 16'd1;

    @(posedge clk);
    @(negedge clk);
    s++;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b1;
    rst_s_n = 1'b1;
    pif.pix_valid = 1'b1;
    pif.pix_data = '0;
    sif.pix_valid = 1'b0;
    sif.pix_data = '0;
    reset_model();
    #1;
    rst_n = 1'b0;
    rst_s_n = 1'b0;

    // Reset held for 5 cycles.
    repeat (5) begin
      @(negedge clk);
      check_reset("rst");
    end

    rst_n = 1'b1;
    rst_s_n = 1'b1;
    rel_cyc = cyc;
    reset_model();

    // Frame 0 and start of frame 1, fully fed.
    while (s < 140) step();
    check("first_rd_s", 32'(first_rd_s), 32'(VACT * HT + HACT));
    check("first_de_s", 32'(first_de_s), 32'(VACT * HT + HACT + 1));
    while (s < 425) step();

    // Starve the first 10 active pixels of line 6 in frame 1.
    starve_left = 10;
    while (s < 460) step();
    check("uf_after_10", 32'(uf), 32'd10);
    check("black_de_cycles", 32'(zero_de), 32'd10);
    while (s < 495) step();

    // Asynchronous reset in the middle of an active line (h=20, v=8).
    check("pre_rst_de", 32'(de), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    @(negedge clk);
    check_reset("held_rst");
    rst_n = 1'b1;
    reset_model();
    // Counting resumes at the first edge; hs falls HFP cycles after that.
    while (s < 100) step();
    check("hs_fall_after_rst", 32'(first_hs_fall), 32'(HFP + 1));

    // Saturation instance: every active read starved since release.
    while ((cyc - rel_cyc) < 203 * 256) @(negedge clk);
    check("uf_s_partial", 32'(uf_s), 32'd50600);
    while ((cyc - rel_cyc) < 70000) @(negedge clk);
    check("uf_s_saturated", 32'(uf_s), 32'hFFFF);
    check("rgb_s_black", 32'(rgb_s), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
